// File: rtl/archer_projectile_ctl.sv
// archer_projectile_ctl
// Slot manager and motion sequencer for archer projectiles.
//   - A rising edge on fire arms one buffered shot. The shot spawns into the
//     lowest free slot while idle, once the frame cooldown has expired.
//   - On each accepted frame_tick the block walks every slot, one per cycle.
//     Each active slot moves PROJ_SPEED pixels, or retires at a screen edge.
//   - hit[i] retires slot i on the next edge, whatever the state.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_tick            one-cycle pulse per frame
//   fire                  attack button level
//   pos_x/y_archer        archer centre, 12 bits each
//   flip_hor_archer       1 = archer faces left
//   game_active, char_class, alive   together enable the block
//   hit                   per-slot retire request
//   pos_x/y_proj          packed slot positions, slot i at [i*12 +: 12]
//   projectile_animated   per-slot active bits
//   proj_dir              per-slot direction, 1 = moving left
//   fire_ack              one-cycle pulse on a successful spawn
//   busy                  high while slots are being walked
module archer_projectile_ctl #(
    parameter int PROJECTILE_COUNT = 4,
    parameter int PROJ_SPEED       = 4,
    parameter int COOLDOWN_FRAMES  = 20,
    parameter int HOR_MAX          = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic                          fire,
    input  logic [11:0]                   pos_x_archer,
    input  logic [11:0]                   pos_y_archer,
    input  logic                          flip_hor_archer,
    input  logic [1:0]                    game_active,
    input  logic [1:0]                    char_class,
    input  logic                          alive,
    input  logic [PROJECTILE_COUNT-1:0]   hit,
    output logic [PROJECTILE_COUNT*12-1:0] pos_x_proj,
    output logic [PROJECTILE_COUNT*12-1:0] pos_y_proj,
    output logic [PROJECTILE_COUNT-1:0]   projectile_animated,
    output logic [PROJECTILE_COUNT-1:0]   proj_dir,
    output logic                          fire_ack,
    output logic                          busy
);

    localparam int IDX_W = (PROJECTILE_COUNT > 1) ? $clog2(PROJECTILE_COUNT) : 1;
    localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PROJECTILE_COUNT - 1);
    localparam logic [CD_W-1:0]  CD_LOAD    = CD_W'(COOLDOWN_FRAMES);
    localparam logic [12:0]      SPEED_13   = 13'(PROJ_SPEED);
    localparam logic [11:0]      SPEED_12   = 12'(PROJ_SPEED);
    localparam logic [12:0]      HOR_MAX_13 = 13'(HOR_MAX);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CD_W-1:0]             cooldown_q, cooldown_d;
    logic                        pending_q, pending_d;
    logic                        fire_q, fire_d;
    logic [11:0]                 x_q [PROJECTILE_COUNT];
    logic [11:0]                 x_d [PROJECTILE_COUNT];
    logic [11:0]                 y_q [PROJECTILE_COUNT];
    logic [11:0]                 y_d [PROJECTILE_COUNT];
    logic [PROJECTILE_COUNT-1:0] active_q, active_d;
    logic [PROJECTILE_COUNT-1:0] dir_q, dir_d;
    logic                        fire_ack_q, fire_ack_d;
    logic                        busy_q, busy_d;

    logic                        enable_s;
    logic                        fire_edge_s;
    logic                        free_found_s;
    logic [IDX_W-1:0]            free_idx_s;
    logic [11:0]                 cur_x_s;
    logic [12:0]                 right_sum_s;
    logic                        right_retire_s;
    logic                        left_retire_s;

    assign enable_s    = (game_active != 2'd0) && (char_class == 2'd2) && alive;
    assign fire_edge_s = fire && !fire_q && enable_s;

    // Sums are taken at 13 bits so neither range check can wrap.
    assign cur_x_s        = x_q[idx_q];
    assign right_sum_s    = {1'b0, cur_x_s} + SPEED_13;
    assign right_retire_s = (right_sum_s >= HOR_MAX_13);
    assign left_retire_s  = ({1'b0, cur_x_s} < SPEED_13);

    // Lowest-index free slot: scan downward so the last write is the lowest index.
    always_comb begin
        free_found_s = ~&active_q;
        free_idx_s   = '0;
        for (int i = PROJECTILE_COUNT - 1; i >= 0; i--) begin
            free_idx_s = active_q[i] ? free_idx_s : IDX_W'(i);
        end
    end

    // Next-state logic for the sequencer, the slots and the spawn path.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cooldown_d = cooldown_q;
        fire_d     = fire;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        fire_ack_d = 1'b0;
        // A hit retires its slot in every state; a hit on a free slot has no effect.
        active_d   = active_q & ~hit;

        // Only one shot is buffered: edges while pending are absorbed.
        if (fire_edge_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            ST_IDLE: begin
                // frame_tick wins over a spawn in the same cycle.
                if (frame_tick) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                    if (cooldown_q != '0) begin
                        cooldown_d = cooldown_q - CD_W'(1);
                    end else begin
                        cooldown_d = '0;
                    end
                end else if (pending_q && (cooldown_q == '0)) begin
                    // With every slot in use the request is dropped.
                    pending_d = 1'b0;
                    if (free_found_s) begin
                        x_d[free_idx_s]      = pos_x_archer;
                        y_d[free_idx_s]      = pos_y_archer;
                        dir_d[free_idx_s]    = flip_hor_archer;
                        active_d[free_idx_s] = 1'b1;
                        cooldown_d           = CD_LOAD;
                        fire_ack_d           = 1'b1;
                    end else begin
                        fire_ack_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_UPDATE: begin
                // A same-cycle hit on this slot pre-empts its move.
                if (active_q[idx_q] && !hit[idx_q]) begin
                    if (dir_q[idx_q]) begin
                        if (left_retire_s) begin
                            active_d[idx_q] = 1'b0;
                        end else begin
                            x_d[idx_q] = cur_x_s - SPEED_12;
                        end
                    end else begin
                        if (right_retire_s) begin
                            active_d[idx_q] = 1'b0;
                        end else begin
                            x_d[idx_q] = right_sum_s[11:0];
                        end
                    end
                end else begin
                    x_d[idx_q] = x_q[idx_q];
                end
                // Ticks arriving here are ignored.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        // Disabled: drop every slot and all fire bookkeeping; positions hold.
        if (!enable_s) begin
            active_d   = '0;
            pending_d  = 1'b0;
            cooldown_d = '0;
            fire_d     = 1'b0;
            state_d    = ST_IDLE;
            idx_d      = '0;
            fire_ack_d = 1'b0;
        end else begin
            fire_d = fire;
        end

        busy_d = (state_d == ST_UPDATE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cooldown_q <= '0;
            pending_q  <= 1'b0;
            fire_q     <= 1'b0;
            active_q   <= '0;
            dir_q      <= '0;
            fire_ack_q <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < PROJECTILE_COUNT; i++) begin
                x_q[i] <= 12'd0;
                y_q[i] <= 12'd0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cooldown_q <= cooldown_d;
            pending_q  <= pending_d;
            fire_q     <= fire_d;
            active_q   <= active_d;
            dir_q      <= dir_d;
            fire_ack_q <= fire_ack_d;
            busy_q     <= busy_d;
            for (int i = 0; i < PROJECTILE_COUNT; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    for (genvar g = 0; g < PROJECTILE_COUNT; g++) begin : g_pack
        assign pos_x_proj[g*12 +: 12] = x_q[g];
        assign pos_y_proj[g*12 +: 12] = y_q[g];
    end

    assign projectile_animated = active_q;
    assign proj_dir            = dir_q;
    assign fire_ack            = fire_ack_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_archer_projectile_ctl.sv
`timescale 1ns/1ps
module tb_archer_projectile_ctl;

    localparam int N     = 4;
    localparam int SPEED = 4;
    localparam int CD    = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_tick;
    logic            fire;
    logic [11:0]     pos_x_archer;
    logic [11:0]     pos_y_archer;
    logic            flip_hor_archer;
    logic [1:0]      game_active;
    logic [1:0]      char_class;
    logic            alive;
    logic [N-1:0]    hit;
    logic [N*12-1:0] pos_x_proj;
    logic [N*12-1:0] pos_y_proj;
    logic [N-1:0]    projectile_animated;
    logic [N-1:0]    proj_dir;
    logic            fire_ack;
    logic            busy;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors     = 0;
    int          miscompares = 0;
    int          ack_cnt     = 0;
    logic [31:0] got;

    archer_projectile_ctl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .frame_tick          (frame_tick),
        .fire                (fire),
        .pos_x_archer        (pos_x_archer),
        .pos_y_archer        (pos_y_archer),
        .flip_hor_archer     (flip_hor_archer),
        .game_active         (game_active),
        .char_class          (char_class),
        .alive               (alive),
        .hit                 (hit),
        .pos_x_proj          (pos_x_proj),
        .pos_y_proj          (pos_y_proj),
        .projectile_animated (projectile_animated),
        .proj_dir            (proj_dir),
        .fire_ack            (fire_ack),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    // Counts fire_ack pulses, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (fire_ack === 1'b1) ack_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [11:0] px(input int i);
        return pos_x_proj[i*12 +: 12];
    endfunction

    function automatic logic [11:0] py(input int i);
        return pos_y_proj[i*12 +: 12];
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; frame_tick = 1'b0; fire = 1'b0; hit = '0;
        pos_x_archer = 12'd0; pos_y_archer = 12'd0; flip_hor_archer = 1'b0;
        game_active = 2'd1; char_class = 2'd2; alive = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // One frame: tick pulse, then wait until the slot walk has finished.
    task automatic frame();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(N);
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    // Fire pulse; returns at the negedge where fire_ack is expected.
    task automatic press(input int x, input int y, input logic f);
        pos_x_archer = 12'(x); pos_y_archer = 12'(y); flip_hor_archer = f;
        fire = 1'b1;
        cyc(1);
        fire = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 6; k++) sb.push_back('{tag: $sformatf("reset_out%0d", k), val: 32'd0});
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: got = 32'(projectile_animated);
                1: got = 32'(proj_dir);
                2: got = 32'(fire_ack);
                3: got = 32'(busy);
                4: got = 32'(|pos_x_proj);
                default: got = 32'(|pos_y_proj);
            endcase
            e = sb.pop_front(); vectors++;
            if (got !== e.val) begin miscompares++; $display("FAIL %s: got %0h want %0h", e.tag, got, e.val); end
        end
    endtask

    task automatic test_spawn();
        do_reset();
        press(400, 300, 1'b0);
        sb.push_back('{tag: "spawn_ack", val: 32'd1});
        sb.push_back('{tag: "spawn_active", val: 32'd1});
        sb.push_back('{tag: "spawn_x0", val: 32'd400});
        sb.push_back('{tag: "spawn_y0", val: 32'd300});
        sb.push_back('{tag: "spawn_dir0", val: 32'd0});
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: got = 32'(fire_ack);
                1: got = 32'(projectile_animated);
                2: got = 32'(px(0));
                3: got = 32'(py(0));
                default: got = 32'(proj_dir[0]);
            endcase
            e = sb.pop_front(); vectors++;
            if (got !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, got, e.val); end
        end
        cyc(1);
        sb.push_back('{tag: "spawn_ack_low", val: 32'd0});
        e = sb.pop_front(); vectors++;
        if (32'(fire_ack) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, fire_ack, e.val); end
        frames(2);
        // Third frame watched cycle by cycle.
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        sb.push_back('{tag: "busy_in_update", val: 32'd1});
        sb.push_back('{tag: "x0_before_walk", val: 32'(400 + 2*SPEED)});
        e = sb.pop_front(); vectors++;
        if (32'(busy) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, busy, e.val); end
        e = sb.pop_front(); vectors++;
        if (32'(px(0)) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, px(0), e.val); end
        cyc(1);
        sb.push_back('{tag: "x0_after_3_frames", val: 32'(400 + 3*SPEED)});
        e = sb.pop_front(); vectors++;
        if (32'(px(0)) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, px(0), e.val); end
        cyc(N - 1);
        sb.push_back('{tag: "busy_after_walk", val: 32'd0});
        e = sb.pop_front(); vectors++;
        if (32'(busy) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, busy, e.val); end
    endtask

    task automatic test_tick_priority();
        do_reset();
        fire = 1'b1;
        cyc(1);
        fire = 1'b0; frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        sb.push_back('{tag: "tickwin_no_ack", val: 32'd0});
        e = sb.pop_front(); vectors++;
        if (32'(fire_ack) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, fire_ack, e.val); end
        cyc(N);
        sb.push_back('{tag: "tickwin_ack_after_walk", val: 32'd1});
        sb.push_back('{tag: "tickwin_active", val: 32'd1});
        cyc(1);
        e = sb.pop_front(); vectors++;
        if (32'(fire_ack) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, fire_ack, e.val); end
        e = sb.pop_front(); vectors++;
        if (32'(projectile_animated) !== e.val) begin miscompares++; $display("FAIL %s: got %0h want %0h", e.tag, projectile_animated, e.val); end
    endtask

    task automatic test_fill();
        int base;
        do_reset();
        base = ack_cnt;
        for (int k = 0; k < N; k++) begin
            press(100, 10 * (k + 1), 1'b0);
            sb.push_back('{tag: $sformatf("fill_ack%0d", k), val: 32'd1});
            sb.push_back('{tag: $sformatf("fill_active%0d", k), val: 32'((1 << (k + 1)) - 1)});
            e = sb.pop_front(); vectors++;
            if (32'(fire_ack) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, fire_ack, e.val); end
            e = sb.pop_front(); vectors++;
            if (32'(projectile_animated) !== e.val) begin miscompares++; $display("FAIL %s: got %0h want %0h", e.tag, projectile_animated, e.val); end
            cyc(1);
            frames(CD);
        end
        press(999, 999, 1'b1);
        cyc(1);
        sb.push_back('{tag: "fifth_fire_dropped", val: 32'(base + N)});
        sb.push_back('{tag: "fifth_active", val: 32'hF});
        e = sb.pop_front(); vectors++;
        if (32'(ack_cnt) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, ack_cnt, e.val); end
        e = sb.pop_front(); vectors++;
        if (32'(projectile_animated) !== e.val) begin miscompares++; $display("FAIL %s: got %0h want %0h", e.tag, projectile_animated, e.val); end
        for (int k = 0; k < N; k++) begin
            sb.push_back('{tag: $sformatf("fill_x%0d", k), val: 32'(100 + SPEED * CD * (N - k))});
            sb.push_back('{tag: $sformatf("fill_y%0d", k), val: 32'(10 * (k + 1))});
            sb.push_back('{tag: $sformatf("fill_dir%0d", k), val: 32'd0});
            e = sb.pop_front(); vectors++;
            if (32'(px(k)) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, px(k), e.val); end
            e = sb.pop_front(); vectors++;
            if (32'(py(k)) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, py(k), e.val); end
            e = sb.pop_front(); vectors++;
            if (32'(proj_dir[k]) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, proj_dir[k], e.val); end
        end
    endtask

    task automatic test_deferred();
        int base;
        do_reset();
        base = ack_cnt;
        press(50, 60, 1'b0);
        cyc(1);
        frames(5);
        press(70, 80, 1'b1);
        repeat (2) begin
            fire = 1'b1; cyc(1); fire = 1'b0; cyc(1);
        end
        frames(CD - 5 - 1);
        sb.push_back('{tag: "deferred_not_yet", val: 32'(base + 1)});
        e = sb.pop_front(); vectors++;
        if (32'(ack_cnt) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, ack_cnt, e.val); end
        frame();
        sb.push_back('{tag: "deferred_ack_low_at_idle", val: 32'd0});
        e = sb.pop_front(); vectors++;
        if (32'(fire_ack) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, fire_ack, e.val); end
        cyc(1);
        sb.push_back('{tag: "deferred_ack", val: 32'd1});
        sb.push_back('{tag: "deferred_active", val: 32'h3});
        sb.push_back('{tag: "deferred_x1", val: 32'd70});
        sb.push_back('{tag: "deferred_dir1", val: 32'd1});
        e = sb.pop_front(); vectors++;
        if (32'(fire_ack) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, fire_ack, e.val); end
        e = sb.pop_front(); vectors++;
        if (32'(projectile_animated) !== e.val) begin miscompares++; $display("FAIL %s: got %0h want %0h", e.tag, projectile_animated, e.val); end
        e = sb.pop_front(); vectors++;
        if (32'(px(1)) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, px(1), e.val); end
        e = sb.pop_front(); vectors++;
        if (32'(proj_dir[1]) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, proj_dir[1], e.val); end
        frames(2);
        sb.push_back('{tag: "deferred_single_buffered_shot", val: 32'(base + 2)});
        e = sb.pop_front(); vectors++;
        if (32'(ack_cnt) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, ack_cnt, e.val); end
    endtask

    task automatic test_retire();
        // start x, dir, active after frame 1, x after frame 1, active after frame 2
        int tbl[5][5] = '{'{6, 1, 1, 2, 0}, '{4, 1, 1, 0, 0}, '{3, 1, 0, 0, 0},
                         '{1018, 0, 1, 1022, 0}, '{1020, 0, 0, 0, 0}};
        for (int r = 0; r < 5; r++) begin
            do_reset();
            press(tbl[r][0], 100, tbl[r][1][0]);
            cyc(1);
            frame();
            sb.push_back('{tag: $sformatf("retire%0d_act1", r), val: 32'(tbl[r][2])});
            e = sb.pop_front(); vectors++;
            if (32'(projectile_animated[0]) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, projectile_animated[0], e.val); end
            if (tbl[r][2] != 0) begin
                sb.push_back('{tag: $sformatf("retire%0d_x1", r), val: 32'(tbl[r][3])});
                e = sb.pop_front(); vectors++;
                if (32'(px(0)) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, px(0), e.val); end
            end
            frame();
            sb.push_back('{tag: $sformatf("retire%0d_act2", r), val: 32'(tbl[r][4])});
            e = sb.pop_front(); vectors++;
            if (32'(projectile_animated[0]) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, projectile_animated[0], e.val); end
        end
    endtask

    // Three right-moving slots at x = 260, 280, 300.
    task automatic build3();
        do_reset();
        press(100, 10, 1'b0); cyc(1); frames(CD);
        press(200, 20, 1'b0); cyc(1); frames(CD);
        press(300, 30, 1'b0); cyc(1);
    endtask

    task automatic test_hit();
        build3();
        hit = 4'b1000;
        cyc(1);
        hit = '0;
        sb.push_back('{tag: "hit_inactive_ignored", val: 32'h7});
        e = sb.pop_front(); vectors++;
        if (32'(projectile_animated) !== e.val) begin miscompares++; $display("FAIL %s: got %0h want %0h", e.tag, projectile_animated, e.val); end
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
        hit = 4'b0010;
        cyc(1);
        hit = '0;
        sb.push_back('{tag: "hit_during_update", val: 32'h5});
        e = sb.pop_front(); vectors++;
        if (32'(projectile_animated) !== e.val) begin miscompares++; $display("FAIL %s: got %0h want %0h", e.tag, projectile_animated, e.val); end
        cyc(2);
        sb.push_back('{tag: "hit_x0_advanced", val: 32'(100 + 2*CD*SPEED + SPEED)});
        sb.push_back('{tag: "hit_x2_advanced", val: 32'(300 + SPEED)});
        sb.push_back('{tag: "hit_final_active", val: 32'h5});
        e = sb.pop_front(); vectors++;
        if (32'(px(0)) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, px(0), e.val); end
        e = sb.pop_front(); vectors++;
        if (32'(px(2)) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, px(2), e.val); end
        e = sb.pop_front(); vectors++;
        if (32'(projectile_animated) !== e.val) begin miscompares++; $display("FAIL %s: got %0h want %0h", e.tag, projectile_animated, e.val); end
    endtask

    task automatic test_disable();
        int base;
        build3();
        alive = 1'b0;
        cyc(1);
        sb.push_back('{tag: "disable_active_clear", val: 32'd0});
        sb.push_back('{tag: "disable_x0_held", val: 32'(100 + 2*CD*SPEED)});
        e = sb.pop_front(); vectors++;
        if (32'(projectile_animated) !== e.val) begin miscompares++; $display("FAIL %s: got %0h want %0h", e.tag, projectile_animated, e.val); end
        e = sb.pop_front(); vectors++;
        if (32'(px(0)) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, px(0), e.val); end
        base = ack_cnt;
        press(1, 1, 1'b0);
        cyc(1);
        sb.push_back('{tag: "disabled_fire_ignored", val: 32'(base)});
        e = sb.pop_front(); vectors++;
        if (32'(ack_cnt) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, ack_cnt, e.val); end
        alive = 1'b1;
        cyc(1);
        // Cooldown was cleared, so the first shot after re-enable spawns at once.
        press(500, 500, 1'b0);
        sb.push_back('{tag: "reenable_ack", val: 32'd1});
        sb.push_back('{tag: "reenable_x0", val: 32'd500});
        e = sb.pop_front(); vectors++;
        if (32'(fire_ack) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, fire_ack, e.val); end
        e = sb.pop_front(); vectors++;
        if (32'(px(0)) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, px(0), e.val); end
    endtask

    task automatic test_reset_mid_update();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
        sb.push_back('{tag: "midupd_busy", val: 32'd1});
        e = sb.pop_front(); vectors++;
        if (32'(busy) !== e.val) begin miscompares++; $display("FAIL %s: got %0d want %0d", e.tag, busy, e.val); end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) sb.push_back('{tag: $sformatf("async_reset_out%0d", k), val: 32'd0});
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: got = 32'(projectile_animated);
                1: got = 32'(busy);
                2: got = 32'(|pos_x_proj);
                default: got = 32'(|pos_y_proj);
            endcase
            e = sb.pop_front(); vectors++;
            if (got !== e.val) begin miscompares++; $display("FAIL %s: got %0h want %0h", e.tag, got, e.val); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; fire = 1'b0; hit = '0;
        pos_x_archer = 12'd0; pos_y_archer = 12'd0; flip_hor_archer = 1'b0;
        game_active = 2'd0; char_class = 2'd0; alive = 1'b0;
        test_reset();
        test_spawn();
        test_tick_priority();
        test_fill();
        test_deferred();
        test_retire();
        test_hit();
        test_disable();
        test_reset_mid_update();
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
